// File: rtl/keypad_scanner_if.sv
// Keypad-side and game-side signals of the keypad scanner, bundled as one port.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, synchronised row sampling,
// per-sweep classification and a debounce FSM emitting one strobe per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master bus
);

  localparam int unsigned     DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_PRESSED
  } state_t;

  logic [3:0]    row_meta_q;
  logic [3:0]    row_sync_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_idx_q;
  logic [15:0]   hits_q;
  logic [15:0]   hits_d;
  logic          tc;
  logic          sweep_end;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cand_q;
  logic [3:0]    key_q;
  logic          key_valid_q;
  logic          key_held_q;

  logic          hit_any;
  logic          hit_multi;
  logic [3:0]    hit_idx;
  logic          is_none;
  logic          is_single;
  logic [3:0]    sweep_code;
  logic [3:0]    cnt_inc;

  // Hex legend for intersection index {row, col}, column 0 leftmost.
  function automatic logic [3:0] keymap(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'h0;
      4'd13:   code = 4'hF;
      4'd14:   code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tc        = (div_q == DIV_LAST);
  assign sweep_end = tc && (col_idx_q == 2'd3);

  // Accumulated hits including the column being sampled right now, so the
  // column-3 sample takes part in the classification of its own sweep.
  always_comb begin
    logic [3:0] bidx;
    hits_d = hits_q;
    bidx   = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      bidx = {r[1:0], col_idx_q};
      if (!row_sync_q[r]) hits_d[bidx] = 1'b1;
    end
  end

  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (hits_d[i]) begin
        if (hit_any) hit_multi = 1'b1;
        hit_any = 1'b1;
        hit_idx = i[3:0];
      end
    end
    is_none    = !hit_any;
    is_single  = hit_any && !hit_multi;
    sweep_code = keymap(hit_idx);
    cnt_inc    = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= '0;
      row_sync_q <= '0;
      div_q      <= '0;
      col_idx_q  <= '0;
      hits_q     <= '0;
    end else begin
      row_meta_q <= bus.row;
      row_sync_q <= row_meta_q;
      if (tc) begin
        div_q     <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        hits_q    <= (col_idx_q == 2'd3) ? '0 : hits_d;
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  // cnt_q counts qualifying sweeps in ARM and release sweeps in PRESSED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (sweep_end) begin
        case (state_q)
          S_IDLE: begin
            if (is_single) begin
              cand_q <= sweep_code;
              if (DEB_N == 4'd1) begin
                key_q       <= sweep_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= S_PRESSED;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= S_ARM;
              end
            end
          end
          S_ARM: begin
            if (is_single && (sweep_code == cand_q)) begin
              if (cnt_inc == DEB_N) begin
                key_q       <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                state_q     <= S_PRESSED;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (is_none) begin
              if (cnt_inc == DEB_N) begin
                key_held_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= S_IDLE;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.col       = ~(4'b0001 << col_idx_q);
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;

endmodule
